// File: rtl/axba_sched_pkg.sv
// Shared types and default line geometry for the axba decompression scheduler.
// Optional stall-abort logic elsewhere is enabled by AXBA_SCHED_TIMEOUT_EN.
package axba_sched_pkg;

    localparam int WORD_W = 32;
    localparam int BEATS  = 8;
    localparam int LINE_W = BEATS * WORD_W;

    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FIRE,
        WAIT,
        RESP
    } sched_state_e;

endpackage

// File: rtl/axba_rr_arbiter.sv
// Rotate-priority pick: first requester at or after i_ptr, wrapping.
// Purely combinational; the caller latches the grant.
module axba_rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [$clog2(N)-1:0] o_grant,
    output logic                 o_any
);
    import axba_sched_pkg::*;

    localparam int IW = $clog2(N);
    localparam logic [IW:0] NUM = (IW+1)'(N);

    logic [N-1:0]  w_rot;
    logic [IW-1:0] w_off;
    logic [IW:0]   w_sum;

    // Rotate so that bit 0 is the requester under the pointer.
    assign w_rot = N'({i_req, i_req} >> i_ptr);

    always_comb begin
        w_off = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IW'(i);
            end
        end
    end

    assign w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
    assign o_grant = (w_sum >= NUM) ? IW'(w_sum - NUM)
                                    : w_sum[IW-1:0];
    assign o_any   = |i_req;

endmodule

// File: rtl/axba_decomp_scheduler.sv
// Shares one axba decompression engine among NUM_REQ requesters, one line at a time.
// Define AXBA_SCHED_TIMEOUT_EN to abort bursts that stall for TIMEOUT cycles.
module axba_decomp_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int BEATS   = axba_sched_pkg::BEATS,
    parameter int WORD_W  = axba_sched_pkg::WORD_W,
    parameter int ENG_LAT = 1
`ifdef AXBA_SCHED_TIMEOUT_EN
   ,parameter int TIMEOUT = 64
`endif
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WORD_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [WORD_W-1:0]          eng_data [BEATS],
    output logic                       eng_valid,
    input  logic [BEATS*WORD_W-1:0]    eng_result,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [BEATS*WORD_W-1:0]    rsp_data,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic                       err_timeout
);
    import axba_sched_pkg::*;

    localparam int IDW = $clog2(NUM_REQ);
    localparam int LW  = BEATS * WORD_W;
    localparam int BCW = $clog2(BEATS);
    localparam int LCW = $clog2(ENG_LAT + 1);

    sched_state_e    r_state;
    logic [IDW-1:0]  r_grant;
    logic [IDW-1:0]  r_rr_ptr;
    logic [BCW-1:0]  r_beat_cnt;
    logic [LCW-1:0]  r_lat_cnt;
    logic [WORD_W-1:0] r_buf [BEATS];
    logic            r_eng_valid;
    logic            r_rsp_valid;
    logic [LW-1:0]   r_rsp_data;
    logic [IDW-1:0]  r_rsp_id;

    logic [IDW-1:0]     w_pick;
    logic               w_any;
    logic [NUM_REQ-1:0] w_ready;
    logic               w_hs;
    logic               w_last;
    logic [WORD_W-1:0]  w_beat;
    logic [IDW-1:0]     w_next_ptr;

`ifdef AXBA_SCHED_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT);
    logic [TCW-1:0] r_stall;
    logic           r_err;
`endif

    axba_rr_arbiter #(
        .N       (NUM_REQ)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick),
        .o_any   (w_any)
    );

    always_comb begin
        w_ready = '0;
        if (r_state == LOAD) begin
            w_ready[r_grant] = 1'b1;
        end
    end

    always_comb begin
        w_beat = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (r_grant == IDW'(r)) begin
                w_beat = req_data[r*WORD_W +: WORD_W];
            end
        end
    end

    assign w_hs       = |(w_ready & req_valid);
    assign w_last     = (r_beat_cnt == BCW'(BEATS - 1));
    assign w_next_ptr = (r_grant == IDW'(NUM_REQ - 1)) ? '0
                                                       : r_grant + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_beat_cnt  <= '0;
            r_lat_cnt   <= '0;
            r_eng_valid <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
            for (int b = 0; b < BEATS; b++) begin
                r_buf[b] <= '0;
            end
`ifdef AXBA_SCHED_TIMEOUT_EN
            r_stall     <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_eng_valid <= 1'b0;
`ifdef AXBA_SCHED_TIMEOUT_EN
            r_err       <= 1'b0;
`endif
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant    <= w_pick;
                        r_beat_cnt <= '0;
                        r_state    <= LOAD;
`ifdef AXBA_SCHED_TIMEOUT_EN
                        r_stall    <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (w_hs) begin
                        r_buf[r_beat_cnt] <= w_beat;
                        if (w_last) begin
                            r_beat_cnt  <= '0;
                            r_eng_valid <= 1'b1;
                            r_state     <= FIRE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
`ifdef AXBA_SCHED_TIMEOUT_EN
                    // A stalled burst is dropped whole; the requester loses its turn.
                    if (w_hs) begin
                        r_stall <= '0;
                    end else if (r_stall == TCW'(TIMEOUT - 1)) begin
                        r_stall    <= '0;
                        r_err      <= 1'b1;
                        r_beat_cnt <= '0;
                        r_rr_ptr   <= w_next_ptr;
                        r_state    <= IDLE;
                        for (int b = 0; b < BEATS; b++) begin
                            r_buf[b] <= '0;
                        end
                    end else begin
                        r_stall <= r_stall + 1'b1;
                    end
`endif
                end
                FIRE: begin
                    r_lat_cnt <= '0;
                    r_state   <= WAIT;
                end
                WAIT: begin
                    if (r_lat_cnt == LCW'(ENG_LAT - 1)) begin
                        r_rsp_data  <= eng_result;
                        r_rsp_id    <= r_grant;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rr_ptr    <= w_next_ptr;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = w_ready;
    assign eng_data  = r_buf;
    assign eng_valid = r_eng_valid;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;

`ifdef AXBA_SCHED_TIMEOUT_EN
    assign err_timeout = r_err;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axba_decomp_scheduler.sv
// Scoreboard bench for axba_decomp_scheduler with a registered XOR engine model.
// Timeout scenario runs only when AXBA_SCHED_TIMEOUT_EN is defined.
module tb_axba_decomp_scheduler;
    import axba_sched_pkg::*;

    localparam int NR = 4;
    localparam logic [31:0] KEY = 32'h5A5A0F0F;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NR-1:0] req_valid;
    logic [NR*32-1:0] req_data;
    logic [NR-1:0] req_ready;
    logic [31:0]   eng_data [8];
    logic          eng_valid;
    line_t         eng_res;
    logic          rsp_valid;
    logic          rsp_ready;
    line_t         rsp_data;
    logic [1:0]    rsp_id;
    logic          err_timeout;

    logic          tb_v [NR];
    logic [31:0]   tb_d [NR];
    logic [31:0]   eng_key;
    logic [31:0]   T1 [8];

    typedef struct {
        logic [1:0] id;
        line_t      data;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_eng = 0;
    int n_err = 0;
    int err_cyc = 0;
    int start, last, n0;
    bit ok;
    line_t d1;

    always #5 clk = ~clk;

    axba_decomp_scheduler dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .eng_data    (eng_data),
        .eng_valid   (eng_valid),
        .eng_result  (eng_res),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_id      (rsp_id),
        .err_timeout (err_timeout)
    );

    always_comb begin
        for (int r = 0; r < NR; r++) begin
            req_valid[r]         = tb_v[r];
            req_data[r*32 +: 32] = tb_d[r];
        end
    end

    // Engine model: one-cycle latency, output held until the next pulse.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eng_res <= {8{32'hDEADBEEF}};
        end else if (eng_valid) begin
            for (int k = 0; k < 8; k++) begin
                eng_res[k*32 +: 32] <= eng_data[k] ^ eng_key;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, line_t got, line_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected got id=%0d exp none",
                             rsp_id);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_id", 256'(rsp_id), 256'(e.id));
                    chk("rsp_data", rsp_data, e.data);
                end
            end
            if (req_ready != '0) begin
                chk("req_ready_onehot",
                    256'($countones(req_ready)), 256'd1);
            end
            if (eng_valid) n_eng++;
            if (err_timeout) begin
                n_err++;
                err_cyc = cyc;
            end
        end
    end

    function automatic logic [31:0] beat(int r, int l, int k, int pat);
        if (pat == 0) return 32'h11111111 * (k + 1);
        return {4'hC, 4'(r), 8'(l), 8'h3C, 8'(k)};
    endfunction

    function automatic line_t line_of(int r, int l, logic [31:0] key);
        line_t d;
        for (int k = 0; k < 8; k++) begin
            d[k*32 +: 32] = beat(r, l, k, 1) ^ key;
        end
        return d;
    endfunction

    task automatic push(int r, int l);
        exp_t e;
        e.id   = 2'(r);
        e.data = line_of(r, l, KEY);
        sb.push_back(e);
    endtask

    task automatic wait_hs(input int r);
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (req_ready[r[1:0]]) break;
            n++;
            if (n > 3000) begin
                checks++;
                failures++;
                $display("FAIL wait_hs r=%0d got no ready exp ready", r);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_line(int r, int l, int pat, int gap_at, int gap);
        for (int k = 0; k < 8; k++) begin
            tb_v[r] = 1'b1;
            tb_d[r] = beat(r, l, k, pat);
            wait_hs(r);
            if (k == gap_at) begin
                tb_v[r] = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        tb_v[r] = 1'b0;
    endtask

    task automatic wait_rsp(output bit got);
        int n = 0;
        got = 1'b0;
        while (n < 3000) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            n++;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL wait_rsp got no rsp_valid exp rsp_valid");
        end
    endtask

    task automatic drain(string nm);
        int n = 0;
        while ((sb.size() != 0 || rsp_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_drain"}, 256'(sb.size()), 256'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic void check_zero(string nm);
        line_t ed;
        for (int k = 0; k < 8; k++) ed[k*32 +: 32] = eng_data[k];
        chk({nm, "_req_ready"}, 256'(req_ready), '0);
        chk({nm, "_eng_valid"}, 256'(eng_valid), '0);
        chk({nm, "_rsp_valid"}, 256'(rsp_valid), '0);
        chk({nm, "_rsp_data"}, rsp_data, '0);
        chk({nm, "_rsp_id"}, 256'(rsp_id), '0);
        chk({nm, "_err"}, 256'(err_timeout), '0);
        chk({nm, "_eng_data"}, ed, '0);
    endfunction

    task automatic do_reset();
        for (int r = 0; r < NR; r++) tb_v[r] = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        T1 = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
               32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
        for (int r = 0; r < NR; r++) begin
            tb_v[r] = 1'b0;
            tb_d[r] = '0;
        end
        rsp_ready = 1'b1;
        eng_key   = '0;
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single requester, identity engine, latency check.
        for (int k = 0; k < 8; k++) d1[k*32 +: 32] = T1[k];
        sb.push_back('{id: 2'd0, data: d1});
        fork
            send_line(0, 0, 0, -1, 0);
            begin
                start = cyc;
                wait_rsp(ok);
                if (ok) chk("t1_latency", 256'(cyc - start), 256'd11);
            end
        join
        drain("t1");

        // All four requesters contend: strict rotation.
        do_reset();
        eng_key = KEY;
        for (int l = 0; l < 3; l++) begin
            for (int r = 0; r < NR; r++) push(r, l);
        end
        fork
            for (int l = 0; l < 3; l++) send_line(0, l, 1, -1, 0);
            for (int l = 0; l < 3; l++) send_line(1, l, 1, -1, 0);
            for (int l = 0; l < 3; l++) send_line(2, l, 1, -1, 0);
            for (int l = 0; l < 3; l++) send_line(3, l, 1, -1, 0);
        join
        drain("t2");

        // Five-cycle gap after beat 3.
        n0 = n_eng;
        push(2, 7);
        send_line(2, 7, 1, 3, 5);
        drain("t3");
        chk("t3_eng_pulses", 256'(n_eng - n0), 256'd1);

        // Back-pressure on the response port.
        do_reset();
        push(0, 4);
        push(1, 4);
        rsp_ready = 1'b0;
        fork
            send_line(0, 4, 1, -1, 0);
            send_line(1, 4, 1, -1, 0);
            begin
                wait_rsp(ok);
                for (int i = 0; i < 20; i++) begin
                    if (i > 0) @(negedge clk);
                    chk("t4_hold_valid", 256'(rsp_valid), 256'd1);
                    chk("t4_hold_data", rsp_data, line_of(0, 4, KEY));
                    chk("t4_hold_id", 256'(rsp_id), 256'd0);
                    chk("t4_no_ready", 256'(req_ready), 256'd0);
                end
                @(posedge clk);
                #1 rsp_ready = 1'b1;
            end
        join
        drain("t4");

        // Reset in the middle of a burst.
        do_reset();
        push(2, 5);
        send_line(2, 5, 1, -1, 0);
        drain("t5a");
        for (int k = 0; k < 4; k++) begin
            tb_v[3] = 1'b1;
            tb_d[3] = beat(3, 9, k, 1);
            wait_hs(3);
        end
        tb_d[3] = beat(3, 9, 4, 1);
        #2 reset_n = 1'b0;
        #1 check_zero("t5_async");
        tb_v[3] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        push(1, 6);
        push(3, 6);
        fork
            send_line(1, 6, 1, -1, 0);
            send_line(3, 6, 1, -1, 0);
        join
        drain("t5b");

`ifdef AXBA_SCHED_TIMEOUT_EN
        do_reset();
        push(2, 8);
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    tb_v[1] = 1'b1;
                    tb_d[1] = beat(1, 8, k, 1);
                    wait_hs(1);
                end
                tb_v[1] = 1'b0;
                last = cyc;
            end
            send_line(2, 8, 1, -1, 0);
        join
        drain("t6");
        chk("t6_err_delay", 256'(err_cyc - last), 256'd64);
        chk("err_count", 256'(n_err), 256'd1);
`else
        chk("err_count", 256'(n_err), 256'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
